partial_product_gen: RTL

Sequential shift-and-add multiplier front end. It accepts one unsigned multiplicand/multiplier pair per operation and emits one shifted partial product per cycle, LSB of the multiplier first. It sits directly upstream of `accumulator` and drives its `i_bit_shifted` input, so the accumulator register holds the full product once `o_done` fires. It also provides a clear pulse for the accumulator between operations.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/partial_product_gen_if.sv | 55 +++++
 rtl/partial_product_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shift-and-add multiplier
// front end (partial_product_gen).
//   IN_WIDTH_DEF / OUT_WIDTH_DEF : default operand / partial-product widths
//   cnt_width()                  : bit-counter width for a given operand width
//   state_t + ST_* constants     : controller state encoding (IDLE/RUN/FLUSH)
package mult_pkg;

  localparam int IN_WIDTH_DEF  = 16;
  localparam int OUT_WIDTH_DEF = 32;

  // Counter indexes multiplier bits 0..w-1, so $clog2(w) bits suffice.
  // Clamp to 1 so a 1-bit operand still gets a legal vector.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/partial_product_gen_if.sv
// partial_product_gen_if: operand/start inputs and partial-product outputs
// of partial_product_gen bundled together.
//   i_run, i_multiplicand, i_multiplier : start request and operands
//   o_bit_shifted, o_valid              : partial product stream to the accumulator
//   o_acc_clear, o_busy, o_done         : accumulator clear, activity, completion
//   dbg_state                           : controller state, for observation only
//
// Handshake: there is no ready signal. i_run is sampled only while the
// block is idle (o_busy=0, which includes the o_done cycle); a sampled
// i_run=1 accepts the operands on that clock edge. Outputs are a
// free-running stream: o_valid qualifies o_bit_shifted, which is zero
// whenever o_valid is low, and the consumer must take it every cycle.
// Modports: master = the side that starts operations, slave = the multiplier.
interface partial_product_gen_if
  import mult_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
);

  logic                 i_run;
  logic [IN_WIDTH-1:0]  i_multiplicand;
  logic [IN_WIDTH-1:0]  i_multiplier;
  logic [OUT_WIDTH-1:0] o_bit_shifted;
  logic                 o_valid;
  logic                 o_acc_clear;
  logic                 o_busy;
  logic                 o_done;
  state_t               dbg_state;

  modport master (
    output i_run,
    output i_multiplicand,
    output i_multiplier,
    input  o_bit_shifted,
    input  o_valid,
    input  o_acc_clear,
    input  o_busy,
    input  o_done,
    input  dbg_state
  );

  modport slave (
    input  i_run,
    input  i_multiplicand,
    input  i_multiplier,
    output o_bit_shifted,
    output o_valid,
    output o_acc_clear,
    output o_busy,
    output o_done,
    output dbg_state
  );

endinterface

// File: rtl/partial_product_gen.sv
// partial_product_gen: sequential shift-and-add multiplier front end.
// Accepts an unsigned multiplicand/multiplier pair and emits one shifted
// partial product per cycle (multiplier LSB first) for a downstream
// accumulator that adds o_bit_shifted every cycle. Sequence per operation:
// one o_acc_clear cycle, IN_WIDTH valid partial products, then an o_done
// cycle in which the accumulator holds the full product.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : partial_product_gen_if.slave (operands, start, stream, status)
module partial_product_gen
  import mult_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  partial_product_gen_if.slave  bus
);

  // The full product is exactly 2*IN_WIDTH bits; any other width would
  // either truncate the largest shift or waste accumulator bits.
  if (OUT_WIDTH != 2 * IN_WIDTH) begin : g_width_check
    $error("partial_product_gen: OUT_WIDTH must equal 2*IN_WIDTH");
  end

  localparam int                CNT_W    = cnt_width(IN_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_WIDTH - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IN_WIDTH-1:0]   mcand_q;
  logic [IN_WIDTH-1:0]   mplier_q;
  logic [OUT_WIDTH-1:0]  pp_q;
  logic                  valid_q;
  logic                  clear_q;
  logic                  done_q;

  logic [OUT_WIDTH-1:0]  mcand_ext;
  logic [OUT_WIDTH-1:0]  pp_next;

  // Zero-extend before shifting so the top bits of the multiplicand are
  // never lost; the largest shift (IN_WIDTH-1) still fits in OUT_WIDTH.
  always_comb begin
    mcand_ext = OUT_WIDTH'(mcand_q);
    pp_next   = '0;
    if (mplier_q[cnt_q]) begin
      pp_next = mcand_ext << cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      pp_q     <= '0;
      valid_q  <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Pulses and the stream default to zero: the accumulator adds every
      // cycle, so anything other than a RUN cycle must present 0.
      pp_q    <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.i_run) begin
            mcand_q  <= bus.i_multiplicand;
            mplier_q <= bus.i_multiplier;
            cnt_q    <= '0;
            clear_q  <= 1'b1;
            state_q  <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Zero multiplier bits still take a cycle: latency is fixed.
          pp_q    <= pp_next;
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          // The last partial product is being added this cycle, so the
          // accumulator holds the product in the cycle after this edge.
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_bit_shifted = pp_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_acc_clear   = clear_q;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_done        = done_q;
  assign bus.dbg_state     = state_q;

endmodule
